// File: rtl/reg_dump_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_reader_pkg
// Brief    : Shared defaults and state encoding for the register-file debug
//            dump reader (also used by the register file and datapath mux).
// Revision : 1.0
// ============================================================================
package reg_dump_reader_pkg;

    // Register file geometry shared with the datapath
    localparam int c_NUM_REGS     = 8;
    localparam int c_DATA_WIDTH   = 16;
    localparam int c_ADDR_WIDTH   = 3;
    localparam int c_HALT_TIMEOUT = 255;

    // Dump sequencer state encoding
    localparam int c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE      = 3'd0;
    localparam state_t c_ST_HALT_WAIT = 3'd1;
    localparam state_t c_ST_READ      = 3'd2;
    localparam state_t c_ST_SEND_LO   = 3'd3;
    localparam state_t c_ST_SEND_HI   = 3'd4;
    localparam state_t c_ST_FINISH    = 3'd5;

endpackage
`default_nettype wire

// File: rtl/reg_dump_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_reader_if
// Brief    : Valid/ready word stream carrying a register value and its index
//            from the dump reader (master) to the debug/UART path (slave).
// Revision : 1.0
// ============================================================================
interface reg_dump_reader_if
    import reg_dump_reader_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH
);

    logic                  outValid;
    logic                  outReady;
    logic [DATA_WIDTH-1:0] outData;
    logic [ADDR_WIDTH-1:0] outIndex;

    modport master (
        output outValid,
        output outData,
        output outIndex,
        input  outReady
    );

    modport slave (
        input  outValid,
        input  outData,
        input  outIndex,
        output outReady
    );

endinterface
`default_nettype wire

// File: rtl/reg_dump_reader_halt_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : halt_timeout_counter
// Brief    : Saturating cycle counter for the CPU halt handshake; flags
//            expiry once the count reaches HALT_TIMEOUT.
// Revision : 1.0
// ============================================================================
module halt_timeout_counter #(
    parameter int HALT_TIMEOUT = 255
) (
    input  logic clock,
    input  logic resetN,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int c_CNT_W = (HALT_TIMEOUT > 0) ? $clog2(HALT_TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(HALT_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_count;

    assign expired = (r_count == c_LIMIT);

    // Count waiting cycles; hold at the limit so the expired flag stays up
    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_reader
// Brief    : Halts the CPU, reads the register file two registers at a time
//            through its combinational read ports and streams every register
//            out as an (index, value) word over a valid/ready interface.
// Revision : 1.0
// ============================================================================
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int NUM_REGS     = c_NUM_REGS,
    parameter int DATA_WIDTH   = c_DATA_WIDTH,
    parameter int ADDR_WIDTH   = c_ADDR_WIDTH,
    parameter int HALT_TIMEOUT = c_HALT_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  start,
    output logic                  haltReq,
    input  logic                  haltAck,
    output logic [ADDR_WIDTH-1:0] readReg1,
    output logic [ADDR_WIDTH-1:0] readReg2,
    input  logic [DATA_WIDTH-1:0] readData1,
    input  logic [DATA_WIDTH-1:0] readData2,
    reg_dump_reader_if.master     outBus,
    output logic                  busy,
    output logic                  done,
    output logic                  timeoutErr
);

    // Pairs are addressed as {pair, 0} and {pair, 1}
    localparam int c_PAIR_W = ADDR_WIDTH - 1;
    localparam logic [c_PAIR_W-1:0] c_LAST_PAIR = c_PAIR_W'(NUM_REGS / 2 - 1);
    localparam logic [c_PAIR_W-1:0] c_PAIR_ONE  = c_PAIR_W'(1);

    state_t                r_state;
    logic [c_PAIR_W-1:0]   r_pair;
    logic [DATA_WIDTH-1:0] r_hiData;
    logic                  r_haltReq;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_timeoutErr;
    logic                  r_outValid;
    logic [DATA_WIDTH-1:0] r_outData;
    logic [ADDR_WIDTH-1:0] r_outIndex;

    logic                  w_timerClear;
    logic                  w_timerEnable;
    logic                  w_timerExpired;

    assign w_timerEnable = (r_state == c_ST_HALT_WAIT);
    assign w_timerClear  = !w_timerEnable;

    halt_timeout_counter #(
        .HALT_TIMEOUT (HALT_TIMEOUT)
    ) u_haltTimer (
        .clock   (clock),
        .resetN  (resetN),
        .clear   (w_timerClear),
        .enable  (w_timerEnable),
        .expired (w_timerExpired)
    );

    // Register-file read addresses are only driven during the single READ cycle
    always_comb begin
        readReg1 = '0;
        readReg2 = '0;
        if (r_state == c_ST_READ) begin
            readReg1 = {r_pair, 1'b0};
            readReg2 = {r_pair, 1'b1};
        end
    end

    // Dump sequencer with registered handshake, status and stream outputs.
    // The low word is loaded straight into the output register at READ; only
    // the high word needs a separate holding register until SEND_HI.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_state      <= c_ST_IDLE;
            r_pair       <= '0;
            r_hiData     <= '0;
            r_haltReq    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeoutErr <= 1'b0;
            r_outValid   <= 1'b0;
            r_outData    <= '0;
            r_outIndex   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state      <= c_ST_HALT_WAIT;
                        r_haltReq    <= 1'b1;
                        r_busy       <= 1'b1;
                        r_timeoutErr <= 1'b0;
                        r_pair       <= '0;
                    end
                end
                c_ST_HALT_WAIT: begin
                    if (haltAck) begin
                        r_state <= c_ST_READ;
                    end else if (w_timerExpired) begin
                        r_state      <= c_ST_IDLE;
                        r_timeoutErr <= 1'b1;
                        r_haltReq    <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                end
                c_ST_READ: begin
                    r_hiData   <= readData2;
                    r_outData  <= readData1;
                    r_outIndex <= {r_pair, 1'b0};
                    r_outValid <= 1'b1;
                    r_state    <= c_ST_SEND_LO;
                end
                c_ST_SEND_LO: begin
                    if (outBus.outReady) begin
                        r_outData  <= r_hiData;
                        r_outIndex <= {r_pair, 1'b1};
                        r_state    <= c_ST_SEND_HI;
                    end
                end
                c_ST_SEND_HI: begin
                    if (outBus.outReady) begin
                        r_outValid <= 1'b0;
                        if (r_pair == c_LAST_PAIR) begin
                            r_state <= c_ST_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_pair  <= r_pair + c_PAIR_ONE;
                            r_state <= c_ST_READ;
                        end
                    end
                end
                c_ST_FINISH: begin
                    r_haltReq <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= c_ST_IDLE;
                end
                default: begin
                    r_state    <= c_ST_IDLE;
                    r_haltReq  <= 1'b0;
                    r_busy     <= 1'b0;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    assign haltReq         = r_haltReq;
    assign busy            = r_busy;
    assign done            = r_done;
    assign timeoutErr      = r_timeoutErr;
    assign outBus.outValid = r_outValid;
    assign outBus.outData  = r_outData;
    assign outBus.outIndex = r_outIndex;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_dump_reader
// Brief    : Directed self-checking bench for reg_dump_reader with a small
//            register file model and a delayed halt acknowledge.
// Revision : 1.0
// ============================================================================
module tb_reg_dump_reader;

    logic        clock  = 1'b0;
    logic        resetN = 1'b0;
    logic        start  = 1'b0;
    logic        ackEn  = 1'b0;
    logic [1:0]  ackPipe = 2'b00;
    logic        haltReq;
    logic        haltAck;
    logic        busy;
    logic        done;
    logic        timeoutErr;
    logic [2:0]  readReg1;
    logic [2:0]  readReg2;
    logic [15:0] readData1;
    logic [15:0] readData2;

    logic [15:0] regFile [0:7];
    logic [15:0] expWord [0:7];

    int errors = 0;
    int checks = 0;

    // Per-dump observations
    int          nWords;
    int          nDone;
    int          doneCyc;
    int          dropCyc;
    int          stallBad;
    int          wIdx  [0:15];
    logic [15:0] wData [0:15];
    int          wCyc  [0:15];
    logic [5:0]  rrLog [0:127];

    reg_dump_reader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus ();

    reg_dump_reader #(
        .NUM_REGS     (8),
        .DATA_WIDTH   (16),
        .ADDR_WIDTH   (3),
        .HALT_TIMEOUT (255)
    ) dut (
        .clock      (clock),
        .resetN     (resetN),
        .start      (start),
        .haltReq    (haltReq),
        .haltAck    (haltAck),
        .readReg1   (readReg1),
        .readReg2   (readReg2),
        .readData1  (readData1),
        .readData2  (readData2),
        .outBus     (bus),
        .busy       (busy),
        .done       (done),
        .timeoutErr (timeoutErr)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Combinational register file read ports
    assign readData1 = regFile[readReg1];
    assign readData2 = regFile[readReg2];

    // CPU model: acknowledges the halt two cycles after the request
    always @(posedge clock) ackPipe <= {ackPipe[0], haltReq & ackEn};
    assign haltAck = ackPipe[1];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic startDump();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Observe one dump starting at cycle 1 after the start edge
    task automatic runDump(input bit toggle, input int injectIdx, input int maxCyc);
        logic        prevStall;
        logic [15:0] prevData;
        logic [2:0]  prevIdx;
        logic        rdy;
        bit          injected;
        nWords = 0; nDone = 0; doneCyc = -1; dropCyc = -1; stallBad = 0;
        prevStall = 1'b0; prevData = '0; prevIdx = '0; injected = 0;
        for (int c = 1; c <= maxCyc; c++) begin
            if (prevStall && (bus.outValid !== 1'b1 || bus.outData !== prevData ||
                              bus.outIndex !== prevIdx))
                stallBad++;
            if (c < 128) rrLog[c] = {readReg1, readReg2};
            if (done === 1'b1) begin
                nDone++;
                doneCyc = c;
            end
            if (nDone > 0 && dropCyc < 0 && haltReq === 1'b0) dropCyc = c;
            start = 1'b0;
            if (injectIdx >= 0 && !injected && bus.outValid === 1'b1 &&
                bus.outIndex === injectIdx[2:0]) begin
                start    = 1'b1;
                injected = 1;
            end
            rdy = toggle ? (((c - 1) % 4 == 0) || ((c - 1) % 4 == 3)) : 1'b1;
            bus.outReady = rdy;
            if (bus.outValid === 1'b1 && rdy) begin
                if (nWords < 16) begin
                    wIdx[nWords]  = int'(bus.outIndex);
                    wData[nWords] = bus.outData;
                    wCyc[nWords]  = c;
                end
                nWords++;
            end
            prevStall = (bus.outValid === 1'b1) && !rdy;
            prevData  = bus.outData;
            prevIdx   = bus.outIndex;
            tick();
        end
        start = 1'b0;
        bus.outReady = 1'b1;
    endtask

    task automatic verifyWords(input string tag);
        check({tag, ".count"}, nWords, 8);
        check({tag, ".doneCount"}, nDone, 1);
        check({tag, ".stallStable"}, stallBad, 0);
        for (int k = 0; k < 8; k++) begin
            if (k < nWords) begin
                check($sformatf("%s.idx%0d", tag, k), wIdx[k], k);
                check($sformatf("%s.data%0d", tag, k), wData[k], expWord[k]);
            end
        end
    endtask

    initial begin
        int   toCyc;
        bit   sawValid;
        bit   sawDone;
        logic haltBefore;
        bit   found;

        bus.outReady = 1'b1;
        regFile[0] = 16'h0000; regFile[1] = 16'h1111;
        regFile[2] = 16'h0100; regFile[3] = 16'h3333;
        regFile[4] = 16'h4444; regFile[5] = 16'h5555;
        regFile[6] = 16'h6666; regFile[7] = 16'h7777;
        for (int k = 0; k < 8; k++) expWord[k] = regFile[k];

        // Reset state
        resetN = 1'b0;
        repeat (3) tick();
        check("rst.haltReq", haltReq, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.timeoutErr", timeoutErr, 0);
        check("rst.outValid", bus.outValid, 0);
        check("rst.outData", bus.outData, 0);
        check("rst.outIndex", bus.outIndex, 0);
        check("rst.readReg1", readReg1, 0);
        check("rst.readReg2", readReg2, 0);
        resetN = 1'b1;
        tick();

        // Full-rate dump with ack two cycles after request
        ackEn = 1'b1;
        startDump();
        check("t1.haltReq", haltReq, 1);
        check("t1.busy", busy, 1);
        runDump(1'b0, -1, 40);
        verifyWords("t1");
        check("t1.firstCyc", wCyc[0], 5);
        check("t1.word1Cyc", wCyc[1], 6);
        check("t1.bubbleCyc", wCyc[2], 8);
        check("t1.lastCyc", wCyc[7], 15);
        check("t1.doneCyc", doneCyc, 16);
        check("t1.haltDropCyc", dropCyc, 17);
        check("t1.readPair0", rrLog[4], 6'b000_001);
        check("t1.readIdle", rrLog[5], 6'b000_000);
        check("t1.readPair1", rrLog[7], 6'b010_011);
        check("t1.readPair3", rrLog[13], 6'b110_111);
        check("t1.busyAfter", busy, 0);

        // Back-pressure pattern 1,0,0,1
        startDump();
        runDump(1'b1, -1, 60);
        verifyWords("t2");
        check("t2.lastCyc", wCyc[7], 21);

        // Halt handshake timeout
        ackEn = 1'b0;
        startDump();
        toCyc = -1; sawValid = 0; sawDone = 0; haltBefore = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (bus.outValid === 1'b1) sawValid = 1;
            if (done === 1'b1) sawDone = 1;
            if (timeoutErr === 1'b1) begin
                toCyc = c;
                break;
            end
            haltBefore = haltReq;
            tick();
        end
        check("t3.timeoutCyc", toCyc, 257);
        check("t3.haltReqBefore", haltBefore, 1);
        check("t3.haltReqAfter", haltReq, 0);
        check("t3.busy", busy, 0);
        check("t3.noValid", sawValid, 0);
        check("t3.noDone", sawDone, 0);
        repeat (3) tick();
        check("t3.sticky", timeoutErr, 1);
        ackEn = 1'b1;
        startDump();
        check("t3.cleared", timeoutErr, 0);
        runDump(1'b0, -1, 40);
        verifyWords("t3b");

        // Start during SEND_LO of index 4 is ignored
        startDump();
        runDump(1'b0, 4, 40);
        verifyWords("t4");

        // Reset during SEND_HI of index 3 while stalled
        startDump();
        found = 0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.outValid === 1'b1 && bus.outIndex === 3'd3) begin
                found = 1;
                break;
            end
            tick();
        end
        check("t5.reachedIdx3", found, 1);
        bus.outReady = 1'b0;
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        bus.outReady = 1'b1;
        check("t5.haltReq", haltReq, 0);
        check("t5.busy", busy, 0);
        check("t5.outValid", bus.outValid, 0);
        check("t5.outData", bus.outData, 0);
        check("t5.outIndex", bus.outIndex, 0);
        check("t5.done", done, 0);
        repeat (4) tick();
        startDump();
        runDump(1'b0, -1, 40);
        verifyWords("t5b");

        // Register rewritten while idle
        regFile[5] = 16'hBEEF;
        expWord[5] = 16'hBEEF;
        startDump();
        runDump(1'b0, -1, 40);
        verifyWords("t6");
        check("t6.r5", wData[5], 16'hBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
